// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//
// Contents:
//   state_e          - controller states (idle, running, result held)
//   digit_is_legal() - true when DIGIT evenly divides WIDTH and 1 <= DIGIT <= WIDTH
//   num_steps()      - number of RUN cycles per operation (WIDTH / DIGIT)
//   count_width()    - width of the step counter, clog2(steps + 1)
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic bit digit_is_legal(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // Guarded against DIGIT = 0 so an illegal configuration reaches the
  // explicit elaboration error instead of a divide-by-zero.
  function automatic int unsigned num_steps(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 1 : (width / digit);
  endfunction

  function automatic int unsigned count_width(input int unsigned width, input int unsigned digit);
    return (num_steps(width, digit) + 1 <= 2) ? 1 : $clog2(num_steps(width, digit) + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder composed of two half-adder stages.
//
// Ports:
//   a, b - addend bits
//   cin  - carry in
//   s    - sum bit
//   cout - carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: a + b.
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;

  // Second half adder: partial sum + cin.
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  // At most one of the two stages can generate a carry.
  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
//
// An operation is accepted in IDLE, then DIGIT bits are processed per cycle
// for WIDTH/DIGIT cycles, after which the result is held in DONE until the
// consumer accepts it. Subtraction is a + ~b + 1.
//
// Parameters:
//   WIDTH - operand/result width
//   DIGIT - bits processed per cycle (must divide WIDTH)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - operand request
//   in_ready  - block accepts operands (IDLE)
//   a, b      - operands
//   sub       - 0: a+b, 1: a-b
//   out_valid - result available (DONE)
//   out_ready - consumer accepts result
//   sum       - registered result
//   cout      - final carry (subtract: 1 = no borrow)
//   ovf       - signed overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned Steps = num_steps(WIDTH, DIGIT);
  localparam int unsigned CntW  = count_width(WIDTH, DIGIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if (!digit_is_legal(WIDTH, DIGIT)) begin : g_illegal_params
    $fatal(1, "serial_add_sub: DIGIT must satisfy 1 <= DIGIT <= WIDTH and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Per-cycle ripple slice over the DIGIT low bits of the operand registers.
  logic [DIGIT:0]   carry_chain;
  logic [DIGIT-1:0] slice_sum;
  logic [WIDTH-1:0] sum_next;

  assign carry_chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    full_adder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (carry_chain[i]),
      .s    (slice_sum[i]),
      .cout (carry_chain[i+1])
    );
  end

  // New digits enter from the MSB end so that after WIDTH/DIGIT steps the
  // first digit computed has arrived at the LSB.
  if (DIGIT == WIDTH) begin : g_sum_full
    assign sum_next = slice_sum;
  end else begin : g_sum_shift
    assign sum_next = {slice_sum, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          count_d = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = carry_chain[DIGIT];
        sum_d   = sum_next;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = StDone;
          cout_d  = carry_chain[DIGIT];
          // On the last step the operand LSB digit holds the original MSBs.
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice_sum[DIGIT-1] != a_q[DIGIT-1]);
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four instances (DIGIT = 1, 2, 4, 16) share the
// stimulus; expected results go into per-instance queues and a monitor per
// instance pops and compares on every output handshake.
module tb_serial_add_sub;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic sub;
  logic [15:0] a;
  logic [15:0] b;

  logic [NDUT-1:0] in_ready;
  logic [NDUT-1:0] out_valid;
  logic [NDUT-1:0] cout;
  logic [NDUT-1:0] ovf;
  logic [15:0]     sum [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pushed = 0;
  int hs_cnt [NDUT];
  exp_t exp_q [NDUT][$];

  bit force_ready = 1'b1;
  bit rand_ready  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int unsigned Dig = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
    localparam int Lat = 16 / Dig;

    serial_add_sub #(
      .WIDTH (16),
      .DIGIT (Dig)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[k]),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid[k]),
      .out_ready (out_ready),
      .sum       (sum[k]),
      .cout      (cout[k]),
      .ovf       (ovf[k])
    );

    // Monitor: samples at the falling edge, mid-cycle.
    initial begin
      int   acc_cyc = 0;
      bit   pend    = 1'b0;
      bit   hold    = 1'b0;
      exp_t held;
      exp_t e;
      hs_cnt[k] = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pend = 1'b0;
          hold = 1'b0;
        end else begin
          if (out_valid[k] && pend) begin
            check($sformatf("D%0d latency", Dig), 32'(cyc - acc_cyc), 32'(Lat));
            pend = 1'b0;
          end
          if (out_valid[k] && hold) begin
            check($sformatf("D%0d stable sum", Dig), 32'(sum[k]), 32'(held.sum));
            check($sformatf("D%0d stable cout", Dig), 32'(cout[k]), 32'(held.cout));
            check($sformatf("D%0d stable ovf", Dig), 32'(ovf[k]), 32'(held.ovf));
          end
          if (out_valid[k] && out_ready) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("D%0d unexpected result", Dig), 32'(sum[k]), 32'hFFFF_FFFF);
            end else begin
              e = exp_q[k].pop_front();
              check($sformatf("D%0d sum", Dig), 32'(sum[k]), 32'(e.sum));
              check($sformatf("D%0d cout", Dig), 32'(cout[k]), 32'(e.cout));
              check($sformatf("D%0d ovf", Dig), 32'(ovf[k]), 32'(e.ovf));
            end
            hs_cnt[k]++;
            hold = 1'b0;
          end else if (out_valid[k]) begin
            hold = 1'b1;
            held = {sum[k], cout[k], ovf[k]};
          end else begin
            hold = 1'b0;
          end
          if (in_valid && in_ready[k]) begin
            pend    = 1'b1;
            acc_cyc = cyc + 1;
          end
        end
      end
    end
  end

  // out_ready driver; stimulus steers it through force_ready / rand_ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  task automatic wait_all_idle();
    int t = 0;
    while (!(&in_ready) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!(&in_ready)) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle timeout: in_ready=%b, expected 1111", in_ready);
    end
  endtask

  task automatic wait_all_valid();
    int t = 0;
    while (!(&out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!(&out_valid)) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid timeout: out_valid=%b, expected 1111", out_valid);
    end
  endtask

  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                       input bit push, input logic [15:0] es, input logic ec, input logic eo);
    wait_all_idle();
    if (push) begin
      for (int k = 0; k < NDUT; k++) exp_q[k].push_back({es, ec, eo});
      n_pushed++;
    end
    a        = va;
    b        = vb;
    sub      = vs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom();
    b        = $urandom();
    sub      = 1'($urandom_range(0, 1));
  endtask

  // Reference: signed range test for ovf, unsigned range test for carry.
  task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                       output logic [15:0] es, output logic ec, output logic eo);
    int sr;
    int ur;
    if (vs) begin
      sr = int'($signed(va)) - int'($signed(vb));
      ur = int'(va) - int'(vb);
      ec = (va >= vb);
    end else begin
      sr = int'($signed(va)) + int'($signed(vb));
      ur = int'(va) + int'(vb);
      ec = (ur > 65535);
    end
    es = ur[15:0];
    eo = (sr > 32767) || (sr < -32768);
  endtask

  vec_t vecs [11];

  initial begin
    logic [15:0] ra, rb, es;
    logic        rs, ec, eo;
    int          hs_before [NDUT];

    vecs = '{
      '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
      '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
      '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1},
      '{16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0},
      '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1}
    };

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset in_ready %0d", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("reset out_valid %0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset sum %0d", k), 32'(sum[k]), 32'd0);
      check($sformatf("reset cout %0d", k), 32'(cout[k]), 32'd0);
      check($sformatf("reset ovf %0d", k), 32'(ovf[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, consumer always ready.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].s, vecs[i].c, vecs[i].o);
    end

    // Backpressure: hold out_ready low in DONE while inputs churn.
    wait_all_idle();
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) hs_before[k] = hs_cnt[k];
    issue(16'h5555, 16'hAAAA, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_all_valid();
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      a        = $urandom();
      b        = $urandom();
      sub      = ~sub;
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("bp in_ready %0d", k), 32'(in_ready[k]), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    in_valid    = 1'b0;
    force_ready = 1'b1;
    wait_all_idle();
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("bp handshakes %0d", k), 32'(hs_cnt[k] - hs_before[k]), 32'd1);
    end

    // Asynchronous reset 8 cycles into RUN (DIGIT=1 still running).
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    check("rst pre out_valid D1", 32'(out_valid[0]), 32'd0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst in_ready %0d", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("rst out_valid %0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("rst sum %0d", k), 32'(sum[k]), 32'd0);
      check($sformatf("rst cout %0d", k), 32'(cout[k]), 32'd0);
      check($sformatf("rst ovf %0d", k), 32'(ovf[k]), 32'd0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);

    // Randomised operands and stalls against the reference model.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, es, ec, eo);
      wait_all_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(ra, rb, rs, 1'b1, es, ec, eo);
    end
    rand_ready  = 1'b0;
    force_ready = 1'b1;
    wait_all_idle();
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("total handshakes %0d", k), 32'(hs_cnt[k]), 32'(n_pushed));
      check($sformatf("leftover expected %0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH are required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result, registered.
REQ-013 SHALL have port cout  output  1  final carry out; in subtract mode 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement three states: IDLE, RUN and DONE.
REQ-016 IDLE SHALL drive in_ready=1 and out_valid=0.
REQ-017 On an IDLE edge with in_valid=1, the block SHALL capture a, b^{WIDTH{sub}}, carry=sub and count=0, then enter RUN.
REQ-018 a, b and sub SHALL be ignored at all other times.
REQ-019 Each RUN cycle SHALL add the DIGIT LSBs of both operand shift registers plus the carry, shift the DIGIT result bits into sum from the MSB end, update the carry, shift the operands right by DIGIT, and increment count.
REQ-020 After WIDTH/DIGIT RUN cycles the block SHALL enter DONE.
REQ-021 Latency: with the operand handshake at edge N, out_valid SHALL be 1 immediately after edge N+WIDTH/DIGIT.
REQ-022 On entering DONE, cout SHALL equal the final carry and ovf SHALL equal (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted b.
REQ-023 DONE SHALL drive out_valid=1 and in_ready=0.
REQ-024 sum, cout and ovf SHALL stay stable while out_valid=1 and out_ready=0, for unbounded backpressure.
REQ-025 On a DONE edge with out_ready=1, the block SHALL return to IDLE.
REQ-026 The next operand SHALL be accepted no earlier than the following edge (no overlap).
REQ-027 in_ready SHALL be 0 throughout RUN and DONE; in_valid during these states SHALL be ignored and not queued.
REQ-028 out_ready SHALL be ignored while out_valid=0.
REQ-029 sum, cout and ovf SHALL hold the last completed result outside RUN and SHALL be undefined for consumers while out_valid=0.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH with no saturation.
REQ-031 count SHALL be clog2(WIDTH/DIGIT+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0, count=0 and operand registers=0.
REQ-033 A reset asserted in RUN or DONE SHALL discard the in-flight operation with no output handshake.
REQ-034 After rst is released, the first clk edge with in_valid=1 SHALL be accepted normally.

Structure
REQ-035 Package serial_add_sub_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the parameter-legality check constant/function.
REQ-036 A sub-module full_adder (a, b, cin -> s, cout), built from two half-adder stages, SHALL be instantiated DIGIT times in a generate chain to form the per-cycle ripple slice.
REQ-037 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs except in_ready and out_valid from state.

Verification
REQ-038 WIDTH=16, DIGIT=1, add 0x7FFF+0x0001 -> out_valid exactly 16 cycles after accept; sum=0x8000, cout=0, ovf=1.
REQ-039 Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
REQ-040 Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1; the same operation with DIGIT=4 -> identical results, out_valid 4 cycles after accept.
REQ-041 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> sum, cout and ovf unchanged, in_ready=0, and only one result is handshaken.
REQ-042 Assert rst asynchronously (mid-cycle) 8 cycles into RUN -> out_valid never asserts, all outputs read 0, in_ready=1 during reset, and the next operation 0x0003+0x0004 -> sum=0x0007.
REQ-043 A random self-checking run of 10k operations against a reference model, with random in_valid/out_ready stalls, for DIGIT in {1,2,4,16} -> zero mismatches.
